// File: rtl/tomasulo_rs_mpy.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tomasulo_rs_mpy: reservation station for the 5-cycle non-pipelined MPY unit |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tomasulo_rs_mpy #(
  parameter int N       = 4,
  parameter int WORD_W  = 32,
  parameter int TAG_W   = 4,
  parameter int REG_W   = 5,
  parameter int ROBID_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 disp_vld,
  output logic                 disp_rdy,
  input  logic [REG_W-1:0]     disp_wa,
  input  logic [TAG_W-1:0]     disp_tag,
  input  logic [ROBID_W-1:0]   disp_robid,
  input  logic [1:0]           disp_src_rdy,
  input  logic [2*TAG_W-1:0]   disp_src_tag,
  input  logic [2*WORD_W-1:0]  disp_src_data,
  input  logic                 cdb_vld,
  input  logic [TAG_W-1:0]     cdb_tag,
  input  logic [WORD_W-1:0]    cdb_wdata,
  output logic                 iss_vld_r,
  output logic [2*WORD_W-1:0]  iss_rdata_r,
  output logic [REG_W-1:0]     iss_wa_r,
  output logic [TAG_W-1:0]     iss_tag_r,
  output logic [ROBID_W-1:0]   iss_robid_r,
  input  logic                 iss_busy_r
);

  localparam int IDX_W = $clog2(N);

  logic [N-1:0]        vld_q, vld_d;
  logic [REG_W-1:0]    wa_q[N], wa_d[N];
  logic [TAG_W-1:0]    tag_q[N], tag_d[N];
  logic [ROBID_W-1:0]  robid_q[N], robid_d[N];
  logic [1:0]          rdy_q[N], rdy_d[N];
  logic [TAG_W-1:0]    stag_q[N][2], stag_d[N][2];
  logic [WORD_W-1:0]   data_q[N][2], data_d[N][2];
  // age_q[i][j] set means entry i is older than entry j
  logic [N-1:0]        age_q[N], age_d[N];

  logic                iss_vld_q, iss_vld_d;
  logic [2*WORD_W-1:0] iss_rdata_q, iss_rdata_d;
  logic [REG_W-1:0]    iss_wa_q, iss_wa_d;
  logic [TAG_W-1:0]    iss_tag_q, iss_tag_d;
  logic [ROBID_W-1:0]  iss_robid_q, iss_robid_d;

  logic [N-1:0]        ready;
  logic [N-1:0]        sel_oh;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    free_idx;
  logic                sel_vld;
  logic                disp_fire;

  assign disp_rdy  = ~&vld_q;
  assign disp_fire = disp_vld & disp_rdy;

  always_comb begin
    ready = '0;
    for (int i = 0; i < N; i++) ready[i] = vld_q[i] & rdy_q[i][0] & rdy_q[i][1];
  end

  // An entry wins if no other ready entry is older than it
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      sel_oh[i] = ready[i];
      for (int j = 0; j < N; j++)
        if (j != i && ready[j] && age_q[j][i]) sel_oh[i] = 1'b0;
    end
    for (int i = 0; i < N; i++)
      if (sel_oh[i]) sel_idx = i[IDX_W-1:0];
  end

  assign sel_vld = (|ready) & ~iss_busy_r;

  always_comb begin
    free_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (!vld_q[i]) free_idx = i[IDX_W-1:0];
  end

  always_comb begin
    vld_d   = vld_q;
    wa_d    = wa_q;
    tag_d   = tag_q;
    robid_d = robid_q;
    rdy_d   = rdy_q;
    stag_d  = stag_q;
    data_d  = data_q;
    age_d   = age_q;

    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++)
        if (vld_q[i] && !rdy_q[i][k] && cdb_vld && stag_q[i][k] == cdb_tag) begin
          rdy_d[i][k]  = 1'b1;
          data_d[i][k] = cdb_wdata;
        end

    if (sel_vld) vld_d[sel_idx] = 1'b0;

    if (disp_fire) begin
      vld_d[free_idx]   = 1'b1;
      wa_d[free_idx]    = disp_wa;
      tag_d[free_idx]   = disp_tag;
      robid_d[free_idx] = disp_robid;
      for (int k = 0; k < 2; k++) begin
        stag_d[free_idx][k] = disp_src_tag[k*TAG_W +: TAG_W];
        if (disp_src_rdy[k]) begin
          rdy_d[free_idx][k]  = 1'b1;
          data_d[free_idx][k] = disp_src_data[k*WORD_W +: WORD_W];
        end else begin
          // Same-cycle CDB broadcast is captured directly
          rdy_d[free_idx][k]  = cdb_vld && (disp_src_tag[k*TAG_W +: TAG_W] == cdb_tag);
          data_d[free_idx][k] = cdb_wdata;
        end
      end
      age_d[free_idx] = '0;
      for (int j = 0; j < N; j++)
        if (vld_q[j]) age_d[j][free_idx] = 1'b1;
    end
  end

  always_comb begin
    iss_vld_d   = sel_vld;
    iss_rdata_d = iss_rdata_q;
    iss_wa_d    = iss_wa_q;
    iss_tag_d   = iss_tag_q;
    iss_robid_d = iss_robid_q;
    if (sel_vld) begin
      iss_rdata_d = {data_q[sel_idx][1], data_q[sel_idx][0]};
      iss_wa_d    = wa_q[sel_idx];
      iss_tag_d   = tag_q[sel_idx];
      iss_robid_d = robid_q[sel_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      iss_vld_q   <= 1'b0;
      iss_rdata_q <= '0;
      iss_wa_q    <= '0;
      iss_tag_q   <= '0;
      iss_robid_q <= '0;
    end else begin
      vld_q       <= vld_d;
      iss_vld_q   <= iss_vld_d;
      iss_rdata_q <= iss_rdata_d;
      iss_wa_q    <= iss_wa_d;
      iss_tag_q   <= iss_tag_d;
      iss_robid_q <= iss_robid_d;
    end
  end

  // Payload is qualified by vld_q and needs no reset
  always_ff @(posedge clk) begin
    wa_q    <= wa_d;
    tag_q   <= tag_d;
    robid_q <= robid_d;
    rdy_q   <= rdy_d;
    stag_q  <= stag_d;
    data_q  <= data_d;
    age_q   <= age_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(disp_vld && !disp_rdy))
        else $warning("tomasulo_rs_mpy: dispatch dropped, station full");
    end
  end

  assign iss_vld_r   = iss_vld_q;
  assign iss_rdata_r = iss_rdata_q;
  assign iss_wa_r    = iss_wa_q;
  assign iss_tag_r   = iss_tag_q;
  assign iss_robid_r = iss_robid_q;

endmodule
`default_nettype wire
